ci_stim_fpga: RTL and testbench

Biphasic current-stimulation sequencer for a single electrode pair. It drives the four H-bridge switch controls (anode/cathode legs, top/bottom devices) and the current-source enable. It free-runs a fixed pulse train with break-before-make dead times, and an optional passive discharge phase. It is the top of the stimulator FPGA and connects directly to the analog front end.

---
 rtl/ci_stim_pkg.sv | 50 +++++
 rtl/ci_stim_hbridge_guard.sv | 48 ++++
 rtl/ci_stim_fpga.sv | 143 ++++++++++++++
 tb/tb_ci_stim_fpga.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ci_stim_pkg.sv
// ci_stim_pkg: shared constants for the biphasic stimulation sequencer.
//   - segment encoding (A_ARM .. REST) used by the segment state machine
//   - default timing constants, in clocks
//   - H-bridge switch patterns, each {ano_top, ano_bot, cat_top, cat_bot}
//   - decode helpers from segment to switch pattern / current enable
package ci_stim_pkg;

    // Default timing, in clocks of the 3.33 MHz stimulator clock
    localparam int unsigned PERIOD_CLKS_DEF = 3333;
    localparam int unsigned PHASE_CLKS_DEF  = 83;
    localparam int unsigned IPG_CLKS_DEF    = 27;
    localparam int unsigned DEAD_CLKS_DEF   = 2;
    localparam int unsigned DIS_CLKS_DEF    = 100;

    // Segment enumeration
    localparam int unsigned SEG_W = 4;
    localparam logic [3:0] SEG_A_ARM = 4'd0;
    localparam logic [3:0] SEG_A_ON  = 4'd1;
    localparam logic [3:0] SEG_A_OFF = 4'd2;
    localparam logic [3:0] SEG_GAP   = 4'd3;
    localparam logic [3:0] SEG_B_ARM = 4'd4;
    localparam logic [3:0] SEG_B_ON  = 4'd5;
    localparam logic [3:0] SEG_B_OFF = 4'd6;
    localparam logic [3:0] SEG_DIS   = 4'd7;
    localparam logic [3:0] SEG_REST  = 4'd8;

    // Switch patterns {ano_top, ano_bot, cat_top, cat_bot}
    localparam logic [3:0] SW_A   = 4'b1001;
    localparam logic [3:0] SW_B   = 4'b0110;
    localparam logic [3:0] SW_DIS = 4'b0101;
    localparam logic [3:0] SW_OFF = 4'b0000;

    // Requested switch pattern for a segment
    function automatic logic [3:0] seg_switches(input logic [3:0] seg);
        logic [3:0] sw;
        case (seg)
            SEG_A_ARM, SEG_A_ON, SEG_A_OFF: sw = SW_A;
            SEG_B_ARM, SEG_B_ON, SEG_B_OFF: sw = SW_B;
            SEG_DIS:                        sw = SW_DIS;
            default:                        sw = SW_OFF;
        endcase
        return sw;
    endfunction

    // Requested current-source enable for a segment
    function automatic logic seg_curr_ena(input logic [3:0] seg);
        return (seg == SEG_A_ON) || (seg == SEG_B_ON);
    endfunction

endpackage

// File: rtl/ci_stim_hbridge_guard.sv
// ci_stim_hbridge_guard: output register stage for the H-bridge.
// Registers the requested switch pattern and current enable, blocking any
// same-leg top+bottom request and any enable without a closed diagonal.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_sw_req[3:0]  : requested {ano_top, ano_bot, cat_top, cat_bot}
//   i_ena_req      : requested current-source enable
//   o_sw[3:0]      : registered, guarded switch pattern
//   o_ena          : registered, guarded current enable
module ci_stim_hbridge_guard
    import ci_stim_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_sw_req,
    input  logic       i_ena_req,
    output logic [3:0] o_sw,
    output logic       o_ena
);

    logic [3:0] sw_d, sw_q;
    logic       ena_d, ena_q;
    logic       ano_ok, cat_ok, diag_ok;

    // A leg with both devices requested is opened entirely (shoot-through)
    always_comb begin
        ano_ok  = !(i_sw_req[3] && i_sw_req[2]);
        cat_ok  = !(i_sw_req[1] && i_sw_req[0]);
        sw_d    = {ano_ok ? i_sw_req[3:2] : 2'b00,
                   cat_ok ? i_sw_req[1:0] : 2'b00};
        diag_ok = (sw_d == SW_A) || (sw_d == SW_B);
        ena_d   = i_ena_req && diag_ok;
    end

    // Output register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_q  <= SW_OFF;
            ena_q <= 1'b0;
        end else begin
            sw_q  <= sw_d;
            ena_q <= ena_d;
        end
    end

    assign o_sw  = sw_q;
    assign o_ena = ena_q;

endmodule

// File: rtl/ci_stim_fpga.sv
// ci_stim_fpga: free-running biphasic current-stimulation sequencer.
// Produces A_ARM, A_ON, A_OFF, GAP, B_ARM, B_ON, B_OFF, [DIS], REST every
// PERIOD_CLKS clocks. Outputs are registered in ci_stim_hbridge_guard, so the
// outputs after edge n show the segment of cycle n.
// Optional feature macro: CI_STIM_DISCHARGE_EN inserts the DIS segment
// (both low-side switches closed for DIS_CLKS) after B_OFF.
//   i_clk      : clock (3.33 MHz nominal)
//   i_rst      : synchronous active-high reset, restarts at cycle 0
//   o_ano_top  : anode high-side switch
//   o_ano_bot  : anode low-side switch
//   o_cat_top  : cathode high-side switch
//   o_cat_bot  : cathode low-side switch
//   o_curr_ena : current-source enable
module ci_stim_fpga
    import ci_stim_pkg::*;
#(
    parameter int unsigned PERIOD_CLKS = PERIOD_CLKS_DEF,
    parameter int unsigned PHASE_CLKS  = PHASE_CLKS_DEF,
    parameter int unsigned IPG_CLKS    = IPG_CLKS_DEF,
    parameter int unsigned DEAD_CLKS   = DEAD_CLKS_DEF,
    parameter int unsigned DIS_CLKS    = DIS_CLKS_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_ano_top,
    output logic o_ano_bot,
    output logic o_cat_top,
    output logic o_cat_bot,
    output logic o_curr_ena
);

    localparam int unsigned CNT_W = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;

    // A zero gap still needs one all-open cycle between diagonals
    localparam int unsigned GAP_EFF = (IPG_CLKS == 0) ? 1 : IPG_CLKS;

`ifdef CI_STIM_DISCHARGE_EN
    localparam int unsigned DIS_EFF = DIS_CLKS;
`else
    localparam int unsigned DIS_EFF = 0;
`endif

    localparam bit          HAS_DIS     = (DIS_EFF > 0);
    localparam int unsigned ACTIVE_CLKS = 4 * DEAD_CLKS + 2 * PHASE_CLKS + GAP_EFF + DIS_EFF;

    // Down-counter reload values (segment length minus one)
    localparam logic [CNT_W-1:0] LD_DEAD  = (DEAD_CLKS  > 0) ? CNT_W'(DEAD_CLKS - 1)  : '0;
    localparam logic [CNT_W-1:0] LD_PHASE = (PHASE_CLKS > 0) ? CNT_W'(PHASE_CLKS - 1) : '0;
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(GAP_EFF - 1);
    localparam logic [CNT_W-1:0] LD_DIS   = (DIS_CLKS   > 0) ? CNT_W'(DIS_CLKS - 1)   : '0;
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIOD_CLKS - 1);

    // Elaboration-time parameter checks
    if (ACTIVE_CLKS > PERIOD_CLKS) begin : g_err_period
        $error("ci_stim_fpga: active segments exceed PERIOD_CLKS");
    end
    if (PHASE_CLKS == 0) begin : g_err_phase
        $error("ci_stim_fpga: PHASE_CLKS must be at least 1");
    end
    if (DEAD_CLKS == 0) begin : g_err_dead
        $error("ci_stim_fpga: DEAD_CLKS must be at least 1");
    end

    // per_q / seg_q / seg_cnt_q describe the cycle about to be registered
    logic [CNT_W-1:0] per_d, per_q;
    logic [SEG_W-1:0] seg_d, seg_q;
    logic [CNT_W-1:0] seg_cnt_d, seg_cnt_q;
    logic             per_last;
    logic [3:0]       sw_req;
    logic             ena_req;
    logic [3:0]       sw_out;
    logic             ena_out;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            per_q     <= '0;
            seg_q     <= SEG_A_ARM;
            seg_cnt_q <= LD_DEAD;
        end else begin
            per_q     <= per_d;
            seg_q     <= seg_d;
            seg_cnt_q <= seg_cnt_d;
        end
    end

    // Next-state: period wrap takes priority, otherwise count down the segment
    always_comb begin
        seg_d     = seg_q;
        seg_cnt_d = seg_cnt_q;
        per_last  = (per_q == PER_LAST);
        per_d     = per_last ? '0 : per_q + CNT_W'(1);

        if (per_last) begin
            seg_d     = SEG_A_ARM;
            seg_cnt_d = LD_DEAD;
        end else if (seg_cnt_q != '0) begin
            seg_cnt_d = seg_cnt_q - CNT_W'(1);
        end else begin
            case (seg_q)
                SEG_A_ARM: begin seg_d = SEG_A_ON;  seg_cnt_d = LD_PHASE; end
                SEG_A_ON:  begin seg_d = SEG_A_OFF; seg_cnt_d = LD_DEAD;  end
                SEG_A_OFF: begin seg_d = SEG_GAP;   seg_cnt_d = LD_GAP;   end
                SEG_GAP:   begin seg_d = SEG_B_ARM; seg_cnt_d = LD_DEAD;  end
                SEG_B_ARM: begin seg_d = SEG_B_ON;  seg_cnt_d = LD_PHASE; end
                SEG_B_ON:  begin seg_d = SEG_B_OFF; seg_cnt_d = LD_DEAD;  end
                SEG_B_OFF: begin
                    if (HAS_DIS) begin
                        seg_d     = SEG_DIS;
                        seg_cnt_d = LD_DIS;
                    end else begin
                        seg_d     = SEG_REST;
                        seg_cnt_d = '0;
                    end
                end
                SEG_DIS:   begin seg_d = SEG_REST;  seg_cnt_d = '0;       end
                default:   begin seg_d = SEG_REST;  seg_cnt_d = '0;       end
            endcase
        end
    end

    // Segment decode feeding the registered guard stage
    always_comb begin
        sw_req  = seg_switches(seg_q);
        ena_req = seg_curr_ena(seg_q);
    end

    ci_stim_hbridge_guard u_guard (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_sw_req  (sw_req),
        .i_ena_req (ena_req),
        .o_sw      (sw_out),
        .o_ena     (ena_out)
    );

    assign o_ano_top  = sw_out[3];
    assign o_ano_bot  = sw_out[2];
    assign o_cat_top  = sw_out[1];
    assign o_cat_bot  = sw_out[0];
    assign o_curr_ena = ena_out;

endmodule

// File: tb/tb_ci_stim_fpga.sv
// tb_ci_stim_fpga: self-checking bench for ci_stim_fpga.
// Two instances: defaults, and a short-period variant with IPG_CLKS=0 and
// DEAD_CLKS=1. Output vectors are {ano_top, ano_bot, cat_top, cat_bot, ena}.
module tb_ci_stim_fpga;

    localparam logic [4:0] V_OFF   = 5'b00000;
    localparam logic [4:0] V_A_ARM = 5'b10010;
    localparam logic [4:0] V_A_ON  = 5'b10011;
    localparam logic [4:0] V_B_ARM = 5'b01100;
    localparam logic [4:0] V_B_ON  = 5'b01101;
`ifdef CI_STIM_DISCHARGE_EN
    localparam bit         DIS_EN  = 1'b1;
    localparam logic [4:0] V_DIS   = 5'b01010;
`else
    localparam bit         DIS_EN  = 1'b0;
    localparam logic [4:0] V_DIS   = 5'b00000;
`endif

    localparam int P1_PERIOD = 500;
    localparam int P1_DIS    = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic a0t, a0b, c0t, c0b, e0;
    logic a1t, a1b, c1t, c1b, e1;
    logic [4:0] out0, out1;
    assign out0 = {a0t, a0b, c0t, c0b, e0};
    assign out1 = {a1t, a1b, c1t, c1b, e1};

    ci_stim_fpga u_dut0 (
        .i_clk(clk), .i_rst(rst),
        .o_ano_top(a0t), .o_ano_bot(a0b), .o_cat_top(c0t), .o_cat_bot(c0b),
        .o_curr_ena(e0)
    );

    ci_stim_fpga #(
        .PERIOD_CLKS(P1_PERIOD), .PHASE_CLKS(83), .IPG_CLKS(0),
        .DEAD_CLKS(1), .DIS_CLKS(P1_DIS)
    ) u_dut1 (
        .i_clk(clk), .i_rst(rst),
        .o_ano_top(a1t), .o_ano_bot(a1b), .o_cat_top(c1t), .o_cat_bot(c1b),
        .o_curr_ena(e1)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = -1;
    bit in_rst   = 1'b1;
    bit record_en = 1'b0;
    logic [4:0] prev0 = V_OFF;
    logic [4:0] prev1 = V_OFF;
    logic [4:0] trace0 [0:3399];
    logic [4:0] trace1 [0:3399];

    typedef struct {
        int         dut;
        int         cyc;
        logic [4:0] exp;
        string      name;
    } vec_t;
    vec_t tbl[$];

    // Reference: walk the segment list by cumulative length
    function automatic logic [4:0] model(input int n, input int per, input int ph,
                                         input int ipg, input int dd, input int dis);
        int t, e;
        t = n % per;
        e = dd;                        if (t < e) return V_A_ARM;
        e += ph;                       if (t < e) return V_A_ON;
        e += dd;                       if (t < e) return V_A_ARM;
        e += (ipg == 0) ? 1 : ipg;     if (t < e) return V_OFF;
        e += dd;                       if (t < e) return V_B_ARM;
        e += ph;                       if (t < e) return V_B_ON;
        e += dd;                       if (t < e) return V_B_ARM;
        e += DIS_EN ? dis : 0;         if (t < e) return V_DIS;
        return V_OFF;
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Safety invariants on one output vector
    task automatic inv(input string nm, input logic [4:0] cur, input logic [4:0] prev);
        logic leg_ok, diag_ok, bbm_ok;
        leg_ok  = !(cur[4] && cur[3]) && !(cur[2] && cur[1]);
        diag_ok = !cur[0] || (cur[4:1] == 4'b1001) || (cur[4:1] == 4'b0110);
        bbm_ok  = (cur[4:1] == prev[4:1]) || (!cur[0] && !prev[0]);
        chk_int({nm, "_leg_overlap_ok"}, int'(leg_ok), 1);
        chk_int({nm, "_ena_diag_ok"}, int'(diag_ok), 1);
        if (!in_rst) chk_int({nm, "_break_before_make_ok"}, int'(bbm_ok), 1);
    endtask

    // One clock: track cycle index, then check both DUTs on the falling edge
    task automatic tick();
        logic [4:0] x0, x1;
        @(posedge clk);
        if (rst) begin
            in_rst = 1'b1;
            cyc    = -1;
        end else begin
            in_rst = 1'b0;
            cyc++;
        end
        @(negedge clk);
        x0 = in_rst ? V_OFF : model(cyc, 3333, 83, 27, 2, 100);
        x1 = in_rst ? V_OFF : model(cyc, P1_PERIOD, 83, 0, 1, P1_DIS);
        chk("dut0_model", out0, x0);
        chk("dut1_model", out1, x1);
        inv("dut0", out0, prev0);
        inv("dut1", out1, prev1);
        if (record_en && !in_rst && cyc < 3400) begin
            trace0[cyc] = out0;
            trace1[cyc] = out1;
        end
        prev0 = out0;
        prev1 = out1;
    endtask

    initial begin
        int ena_cnt;
        int guard;

        // Landmark vectors
        tbl.push_back('{0, 0,    V_A_ARM, "a_arm_c0"});
        tbl.push_back('{0, 1,    V_A_ARM, "a_arm_c1"});
        tbl.push_back('{0, 2,    V_A_ON,  "a_on_start"});
        tbl.push_back('{0, 84,   V_A_ON,  "a_on_end"});
        tbl.push_back('{0, 85,   V_A_ARM, "a_off_start"});
        tbl.push_back('{0, 86,   V_A_ARM, "a_off_end"});
        tbl.push_back('{0, 87,   V_OFF,   "gap_start"});
        tbl.push_back('{0, 113,  V_OFF,   "gap_end"});
        tbl.push_back('{0, 114,  V_B_ARM, "b_arm_start"});
        tbl.push_back('{0, 116,  V_B_ON,  "b_on_start"});
        tbl.push_back('{0, 198,  V_B_ON,  "b_on_end"});
        tbl.push_back('{0, 199,  V_B_ARM, "b_off_start"});
        tbl.push_back('{0, 200,  V_B_ARM, "b_off_end"});
        tbl.push_back('{0, 201,  V_DIS,   "dis_or_rest_201"});
        tbl.push_back('{0, 300,  V_DIS,   "dis_or_rest_300"});
        tbl.push_back('{0, 301,  V_OFF,   "rest_301"});
        tbl.push_back('{0, 3332, V_OFF,   "rest_last"});
        tbl.push_back('{0, 3333, V_A_ARM, "wrap_a_arm"});
        tbl.push_back('{0, 3335, V_A_ON,  "wrap_a_on"});
        tbl.push_back('{1, 83,   V_A_ON,  "ipg0_a_on_end"});
        tbl.push_back('{1, 84,   V_A_ARM, "ipg0_a_off"});
        tbl.push_back('{1, 85,   V_OFF,   "ipg0_gap"});
        tbl.push_back('{1, 86,   V_B_ARM, "ipg0_b_arm"});
        tbl.push_back('{1, 87,   V_B_ON,  "ipg0_b_on"});
        tbl.push_back('{1, 170,  V_B_ARM, "ipg0_b_off"});
        tbl.push_back('{1, 171,  V_DIS,   "ipg0_dis_or_rest"});
        tbl.push_back('{1, 500,  V_A_ARM, "ipg0_wrap"});

        // Reset held 10 clocks
        rst = 1'b1;
        repeat (10) tick();
        chk("reset_all_zero", out0, V_OFF);

        // Ten free-running periods with invariant monitoring
        rst = 1'b0;
        record_en = 1'b1;
        repeat (10 * 3333 + 5) tick();
        record_en = 1'b0;

        foreach (tbl[i]) begin
            if (tbl[i].dut == 0) chk(tbl[i].name, trace0[tbl[i].cyc], tbl[i].exp);
            else                 chk(tbl[i].name, trace1[tbl[i].cyc], tbl[i].exp);
        end

        ena_cnt = 0;
        for (int i = 0; i < 3333; i++) ena_cnt += int'(trace0[i][0]);
        chk_int("ena_clocks_per_period", ena_cnt, 166);
        ena_cnt = 0;
        for (int i = 84; i <= 86; i++) ena_cnt += int'(trace1[i][0]);
        chk_int("ipg0_ena_low_84_86", ena_cnt, 0);

        // Reset asserted inside A_ON at cycle 50 for 3 clocks
        rst = 1'b1;
        tick();
        rst = 1'b0;
        guard = 0;
        while (cyc != 50 && guard < 100) begin
            tick();
            guard++;
        end
        chk_int("reach_cycle_50", cyc, 50);
        chk("pre_reset_a_on", out0, V_A_ON);
        rst = 1'b1;
        tick();
        chk("mid_pulse_reset_zero", out0, V_OFF);
        chk("mid_pulse_reset_zero_dut1", out1, V_OFF);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("restart_a_arm", out0, V_A_ARM);
        tick();
        tick();
        chk("restart_a_on", out0, V_A_ON);

        // Randomized reset pulses against the reference model
        repeat (12) begin
            repeat ($urandom_range(4000, 1)) tick();
            rst = 1'b1;
            repeat ($urandom_range(5, 1)) tick();
            rst = 1'b0;
        end
        repeat (400) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
